minterm_sweeper: RTL and testbench
==================================

// Module: minterm_sweeper
// PURPOSE
//   Sequential driver/collector for the combinational N-input sum-of-minterms
//   functions in the Quine lab flow. On start, drives every input combination
//   0..2^N-1 onto the function under test, samples its single output, and
//   streams the index of every true minterm downstream over valid/ready.
//   Feeds the minimisation stage; also reports the true-minterm count.
// PARAMETERS
//   N_VARS      11  function input count; vars[0]=a ... vars[10]=k
//   FIFO_DEPTH  4   output index buffer depth (power of 2, >=2)
// PORTS
//   clk      in   1         single clock, rising edge
//   rst      in   1         asynchronous, active-high reset
//   start    in   1         1-cycle pulse; accepted in IDLE or DONE only
//   vars     out  N_VARS    current input combination to function under test
//   func_in  in   1         function output for vars (combinational, same cycle)
//   m_valid  out  1         minterm index available
//   m_ready  in   1         downstream accepts m_index this cycle
//   m_index  out  N_VARS    index of a true minterm, ascending order
//   count    out  N_VARS+1  number of true minterms found this sweep
//   busy     out  1         high in SWEEP and FLUSH
//   done     out  1         high in DONE, held until next start or rst
// BEHAVIOUR
//   Reset: state=IDLE; vars=0, count=0, FIFO empty, m_valid=0, m_index=0,
//     busy=0, done=0. rst mid-sweep aborts immediately; FIFO contents dropped.
//   States: IDLE -start-> SWEEP -last index sampled-> FLUSH -FIFO empty->
//     DONE -start-> SWEEP. start while busy is ignored.
//   Entering SWEEP: vars=0, count=0, done=0 on the same edge.
//   SWEEP, per cycle: stall = func_in & fifo_full. fifo_full is the
//     registered occupancy==FIFO_DEPTH; a same-cycle pop does NOT clear stall.
//     Not stalled: if func_in, push vars and count+=1; then
//     if vars==2^N_VARS-1 go FLUSH (vars holds), else vars+=1.
//     Stalled: vars, count hold; retry next cycle.
//   Latency: index sampled at edge t appears on m_index/m_valid after edge t
//     (one register stage) if FIFO was empty.
//   Handshake: pop on m_valid & m_ready. m_index/m_valid stable while
//     m_valid & ~m_ready. Simultaneous push and pop allowed when not full.
//   FLUSH: no sampling; exit to DONE on the edge where occupancy reaches 0.
//   count: no wrap; all-true function gives exactly 2^N_VARS.
//   vars holds last value (2^N_VARS-1) in FLUSH/DONE; returns to 0 only on
//     start or rst.
// STRUCTURE
//   Shared package lab4_pkg: state enum (IDLE, SWEEP, FLUSH, DONE),
//     N_VARS default, MAX_INDEX constant.
//   One sub-module: minterm_fifo (sync FIFO, width N_VARS, depth FIFO_DEPTH,
//     full/empty/occupancy outputs, async active-high rst).
//   Sweep counter, count register and FSM live in the top.
// TESTING
//   func_in=0, start -> 2048 SWEEP cycles, m_valid never 1, count=0,
//     done rises with busy falling, cycle ~2050.
//   func=(vars==5)|(vars==2047), m_ready=1 -> m_index 5 then 2047, count=2.
//   func_in=1, m_ready=1 -> m_index 0..2047 in order, no gaps,
//     count=2048 (0x800), no stall cycles.
//   func_in=1, m_ready=0 -> 4 pushes (0..3), vars stalls at 4, busy=1;
//     release m_ready -> sweep resumes at 4, no index lost or duplicated.
//   rst asserted at vars=1000 -> all outputs reset values same cycle;
//     start again -> fresh sweep from vars=0, count restarts at 0.
//   start pulsed during SWEEP -> ignored; start in DONE -> new sweep.

Source files
------------

// File: rtl/lab4_pkg.sv
// Shared types and constants for the minterm sweeper: FSM state encoding
// and the default function width.
package lab4_pkg;

  localparam int N_VARS_DEF = 11;
  localparam int MAX_INDEX  = (1 << N_VARS_DEF) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/minterm_fifo.sv
// Small synchronous FIFO buffering true-minterm indices between the sweep
// and the downstream valid/ready consumer. Head entry is visible on rd_data.
module minterm_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW:0]                 occ_q, occ_d;
  logic                        do_push, do_pop;

  assign full      = (occ_q == (AW+1)'(DEPTH));
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;
  // Drive zero while empty so an idle stream never shows stale indices.
  assign rd_data   = empty ? '0 : mem_q[rd_ptr_q];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/minterm_sweeper.sv
// Walks every input combination of a combinational function, queues the
// indices where it is true and streams them out over valid/ready.
module minterm_sweeper
  import lab4_pkg::*;
#(
  parameter int N_VARS     = N_VARS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_VARS-1:0] vars,
  input  logic              func_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_VARS-1:0] m_index,
  output logic [N_VARS:0]   count,
  output logic              busy,
  output logic              done
);

  localparam int               OW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [N_VARS-1:0] LAST_IDX = '1;

  state_e              state_q, state_d;
  logic [N_VARS-1:0]   vars_q, vars_d;
  logic [N_VARS:0]     count_q, count_d;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic [OW-1:0]       occ;

  assign pop     = m_valid & m_ready;
  assign m_valid = ~fifo_empty;
  assign vars    = vars_q;
  assign count   = count_q;
  assign busy    = (state_q == SWEEP) || (state_q == FLUSH);
  assign done    = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    vars_d  = vars_q;
    count_d = count_q;
    push    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SWEEP;
          vars_d  = '0;
          count_d = '0;
        end
      end
      SWEEP: begin
        // Stall uses registered fullness; a pop this cycle frees space only next cycle.
        if (!(func_in && fifo_full)) begin
          push = func_in;
          if (func_in) count_d = count_q + (N_VARS+1)'(1);
          if (vars_q == LAST_IDX) state_d = FLUSH;
          else                    vars_d  = vars_q + N_VARS'(1);
        end
      end
      FLUSH: begin
        if (occ == '0 || (occ == OW'(1) && pop)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vars_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      vars_q  <= vars_d;
      count_q <= count_d;
    end
  end

  minterm_fifo #(
    .WIDTH (N_VARS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wr_data   (vars_q),
    .pop       (pop),
    .rd_data   (m_index),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occ)
  );

endmodule

// File: tb/tb_minterm_sweeper.sv
// Directed bench for minterm_sweeper: table of sweep scenarios plus
// hand-written stall, mid-sweep reset and start-while-busy sequences.
module tb_minterm_sweeper;
  import lab4_pkg::*;

  localparam int N = N_VARS_DEF;

  logic         clk, rst, start, func_in, m_valid, m_ready, busy, done;
  logic [N-1:0] vars, m_index;
  logic [N:0]   count;

  minterm_sweeper #(.N_VARS(N), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .vars(vars), .func_in(func_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index), .count(count),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int fmode;     // 0 none, 1 {5,2047}, 2 all, 3 odd, 4 multiple of 3
    int rmode;     // 0 ready=1, 1 toggling, 2 random, 3 ready=0
    int exp_count;
    int exp_done;  // step count from start to done, -1 = not checked
  } vec_t;

  int           checks = 0, errors = 0;
  int           fmode = 0, rmode = 0, cyc = 0, got = 0;
  int           exp_q[$];
  logic         hold = 1'b0;
  logic [N-1:0] hold_idx = '0;

  function automatic logic fmodel(int mode, logic [N-1:0] v);
    case (mode)
      1:       return (v == 5) || (v == MAX_INDEX);
      2:       return 1'b1;
      3:       return v[0];
      4:       return (int'(v) % 3) == 0;
      default: return 1'b0;
    endcase
  endfunction

  always @* func_in = fmodel(fmode, vars);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic ready_val();
    case (rmode)
      0:       return 1'b1;
      1:       return cyc[0];
      2:       return $urandom_range(0, 3) != 0;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  task automatic monitor();
    if (hold) begin
      checks++;
      if (!(m_valid === 1'b1 && m_index === hold_idx)) begin
        errors++;
        $display("FAIL stable: got valid=%0b idx=%0d expected valid=1 idx=%0d", m_valid, m_index, hold_idx);
      end
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_pop: got idx=%0d expected no more indices", m_index);
      end else begin
        check("m_index", 32'(m_index), 32'(exp_q.pop_front()));
      end
      got++;
    end
    hold     = (m_valid === 1'b1) && (m_ready === 1'b0);
    hold_idx = m_index;
  endtask

  task automatic step(input logic st);
    @(posedge clk);
    #1;
    start   = st;
    m_ready = ready_val();
    @(negedge clk);
    monitor();
    cyc++;
  endtask

  task automatic begin_sweep(input int fm, input int rm);
    fmode = fm;
    rmode = rm;
    exp_q.delete();
    for (int i = 0; i <= MAX_INDEX; i++)
      if (fmodel(fm, N'(i))) exp_q.push_back(i);
    got = 0;
    step(1'b1);
    cyc = 0;
  endtask

  task automatic drain(input int exp_count, input int exp_done);
    int   n;
    logic busy_ok;
    n       = 0;
    busy_ok = 1'b1;
    while (n < 20000) begin
      step(1'b0);
      n++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check("done_reached", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("busy_during_sweep", 32'(busy_ok), 32'd1);
    if (exp_done >= 0) check("done_cycle", 32'(cyc), 32'(exp_done));
    check("count", 32'(count), 32'(exp_count));
    check("indices_popped", 32'(got), 32'(exp_count));
    check("indices_left", 32'(exp_q.size()), 32'd0);
    check("vars_in_done", 32'(vars), 32'(MAX_INDEX));
    check("m_valid_in_done", 32'(m_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vars"},    32'(vars),    32'd0);
    check({tag, "_count"},   32'(count),   32'd0);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_index"}, 32'(m_index), 32'd0);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_done"},    32'(done),    32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{fmode: 0, rmode: 0, exp_count: 0,    exp_done: 2050};
    vecs[1] = '{fmode: 1, rmode: 0, exp_count: 2,    exp_done: 2050};
    vecs[2] = '{fmode: 2, rmode: 0, exp_count: 2048, exp_done: 2050};
    vecs[3] = '{fmode: 3, rmode: 1, exp_count: 1024, exp_done: -1};
    vecs[4] = '{fmode: 4, rmode: 2, exp_count: 683,  exp_done: -1};

    rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    #23;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    for (int i = 0; i < 5; i++) begin
      begin_sweep(vecs[i].fmode, vecs[i].rmode);
      drain(vecs[i].exp_count, vecs[i].exp_done);
    end

    // Downstream blocked: four indices fill the buffer, sweep parks at 4.
    begin_sweep(2, 3);
    repeat (10) step(1'b0);
    check("stall_vars", 32'(vars), 32'd4);
    check("stall_count", 32'(count), 32'd4);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_m_valid", 32'(m_valid), 32'd1);
    check("stall_m_index", 32'(m_index), 32'd0);
    rmode = 0;
    drain(2048, -1);

    // Reset mid-sweep takes effect immediately, then a fresh sweep.
    begin_sweep(2, 0);
    for (int n = 0; n < 1500 && vars !== N'(1000); n++) step(1'b0);
    check("vars_reached_1000", 32'(vars), 32'd1000);
    check("count_at_1000", 32'(count), 32'd1000);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    hold = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    begin_sweep(1, 0);
    drain(2, 2050);

    // start while busy is ignored; start from DONE launches a new sweep.
    begin_sweep(1, 0);
    repeat (101) step(1'b0);
    step(1'b1);
    step(1'b0);
    check("start_ignored_vars", 32'(vars), 32'd102);
    check("start_ignored_busy", 32'(busy), 32'd1);
    drain(2, -1);
    begin_sweep(1, 0);
    drain(2, 2050);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
